bcd_conv_arbiter: RTL and testbench
===================================

// Module: bcd_conv_arbiter
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) shared by two requesters.
//  Round-robin arbiter grants the single conversion engine; FSM sequences load, WIDTH shift steps, result.
//  Sits between producer logic (counters, switch inputs) and the 7-segment display path.
//  Replaces per-requester combinational converters with one time-shared engine.
// PARAMETERS
//  WIDTH   8   binary operand width, bits
//  DIGITS  3   BCD output digits; 10**DIGITS > 2**WIDTH required; initial-block $error if violated
// PORTS
//  clk_pi      in   1          clock; all state on rising edge
//  rst_n_pi    in   1          asynchronous active-low reset
//  req0_pi     in   1          requester 0 conversion request; held until ack0_po
//  num0_pi     in   WIDTH      requester 0 operand; stable while req0_pi high
//  req1_pi     in   1          requester 1 conversion request; held until ack1_po
//  num1_pi     in   WIDTH      requester 1 operand; stable while req1_pi high
//  ack0_po     out  1          1-cycle pulse: requester 0 granted, num0_pi captured this edge
//  ack1_po     out  1          1-cycle pulse: requester 1 granted, num1_pi captured this edge
//  busy_po     out  1          high in SHIFT and DONE states
//  done_po     out  1          1-cycle pulse: bcdnum_po holds new result
//  done_id_po  out  1          requester index of current/last result
//  bcdnum_po   out  4*DIGITS   packed BCD result, digit 0 in [3:0]; holds until next done_po
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; all outputs 0; last_grant=1 (req0 wins first tie).
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: no req: stay. One req: grant it. Both: grant != last_grant. On grant (same edge):
//   operand -> shift reg, BCD accumulator=0, bit_cnt=WIDTH-1, ack pulse, last_grant/done_id_po
//   update, -> SHIFT.
//  SHIFT: per cycle, each BCD digit >4 gets +3, then {acc,shreg} shifts left 1 (MSB first).
//   bit_cnt==0: -> DONE, else bit_cnt-1. Exactly WIDTH SHIFT cycles.
//  DONE: register accumulator -> bcdnum_po, done_po=1 one cycle, -> IDLE. No grant in DONE.
//  Latency: done_po high WIDTH+1 cycles after ack edge; max throughput 1 per WIDTH+2 cycles.
//  Digit adjust 4-bit modulo; accumulator 4*DIGITS bits, never overflows given param rule.
//  Req dropped before ack: ignored, no record. Req held after ack: re-arbitrated next IDLE as new
//   request (requester must drop req the cycle after ack to avoid repeat).
//  Operand changes after ack: no effect on conversion in flight.
//  Reset mid-conversion: abort, no done_po, bcdnum_po cleared; requester must re-request.
//  ack0_po and ack1_po never both high; ack never asserted while busy_po high.
// TESTING
//  1 Reset, req0=1 num0=8'd255 -> ack0 cycle 0, done_po cycle 9, bcdnum_po=12'h255, done_id_po=0.
//  2 num0=0 then num0=8'd100 -> results 12'h000 and 12'h100, each 9 cycles after ack.
//  3 req0=1 (42) and req1=1 (199) same cycle after reset -> ack0 first, 12'h042 id 0; then ack1,
//    12'h199 id 1; repeat tie -> req0 granted (alternation).
//  4 req1 asserted in SHIFT -> no ack until IDLE; ack1 exactly WIDTH+2 cycles after prior ack0.
//  5 rst_n_pi low at SHIFT cycle 4 -> all outputs 0 same cycle, no done_po; new req converts correctly.
//  6 All 0..255 via both requesters, random req gaps -> bcdnum_po == decimal digits of operand
//    (div/mod model); ack/done ordering and ids match scoreboard.

Source files
------------

// File: rtl/bcd_conv_arbiter.sv
// Time-shared binary-to-BCD converter for two requesters.
// A round-robin arbiter picks one request while the engine is idle. The engine then runs
// shift-and-add-3 (double dabble), one operand bit per clock, MSB first. After WIDTH shift
// cycles the result is published on bcdnum_po with a one-cycle done_po pulse.
module bcd_conv_arbiter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                  clk_pi,
    input  logic                  rst_n_pi,
    input  logic                  req0_pi,
    input  logic [WIDTH-1:0]      num0_pi,
    input  logic                  req1_pi,
    input  logic [WIDTH-1:0]      num1_pi,
    output logic                  ack0_po,
    output logic                  ack1_po,
    output logic                  busy_po,
    output logic                  done_po,
    output logic                  done_id_po,
    output logic [4*DIGITS-1:0]   bcdnum_po
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // True when DIGITS decimal digits can hold every WIDTH-bit value.
    function automatic bit digits_ok(input int unsigned w, input int unsigned d);
        longint unsigned p10;
        p10 = 64'd1;
        if (d >= 19) return 1'b1;
        if (w >= 63) return 1'b0;
        for (int unsigned i = 0; i < d; i++) p10 = p10 * 64'd10;
        return p10 > (64'd1 << w);
    endfunction

    if (!digits_ok(WIDTH, DIGITS)) begin : g_bad_params
        $error("bcd_conv_arbiter: 10**DIGITS must exceed 2**WIDTH");
    end

    // Add 3 to every digit above 4 so the next left shift carries into the next digit.
    function automatic logic [BCD_W-1:0] adjust(input logic [BCD_W-1:0] acc);
        logic [BCD_W-1:0] res;
        res = acc;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (acc[4*i +: 4] > 4'd4) res[4*i +: 4] = acc[4*i +: 4] + 4'd3;
        end
        return res;
    endfunction

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_t;

    state_t                 state_q;
    logic [WIDTH-1:0]       shreg_q;
    logic [BCD_W-1:0]       acc_q;
    logic [CNT_W-1:0]       bit_cnt_q;
    logic                   last_grant_q;

    logic                   grant_sel;
    logic                   any_req;
    logic [BCD_W+WIDTH-1:0] shifted;

    // Round-robin choice and the next double-dabble step.
    always_comb begin
        any_req   = req0_pi | req1_pi;
        // On a tie the requester that did not win last time gets the engine.
        grant_sel = (req0_pi && req1_pi) ? ~last_grant_q : req1_pi;
        shifted   = {adjust(acc_q), shreg_q} << 1;
    end

    // Sequencer: arbitrate in idle, shift WIDTH times, then publish the result.
    always_ff @(posedge clk_pi or negedge rst_n_pi) begin
        if (!rst_n_pi) begin
            state_q      <= StIdle;
            shreg_q      <= '0;
            acc_q        <= '0;
            bit_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            ack0_po      <= 1'b0;
            ack1_po      <= 1'b0;
            busy_po      <= 1'b0;
            done_po      <= 1'b0;
            done_id_po   <= 1'b0;
            bcdnum_po    <= '0;
        end else begin
            ack0_po <= 1'b0;
            ack1_po <= 1'b0;
            done_po <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (any_req) begin
                        acc_q        <= '0;
                        bit_cnt_q    <= CNT_W'(WIDTH - 1);
                        busy_po      <= 1'b1;
                        last_grant_q <= grant_sel;
                        done_id_po   <= grant_sel;
                        state_q      <= StShift;
                        if (grant_sel) begin
                            shreg_q <= num1_pi;
                            ack1_po <= 1'b1;
                        end else begin
                            shreg_q <= num0_pi;
                            ack0_po <= 1'b1;
                        end
                    end
                end
                StShift: begin
                    {acc_q, shreg_q} <= shifted;
                    if (bit_cnt_q == '0) begin
                        state_q <= StDone;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - 1'b1;
                    end
                end
                StDone: begin
                    bcdnum_po <= acc_q;
                    done_po   <= 1'b1;
                    busy_po   <= 1'b0;
                    state_q   <= StIdle;
                end
                default: begin
                    busy_po <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Bench for bcd_conv_arbiter: table of single conversions, directed multi-cycle sequences
// (tie alternation, request during shift, reset mid-conversion) and a randomized sweep of
// all operands through both requesters against a cycle-level reference model.
module tb_bcd_conv_arbiter;

    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DIGITS = 3;
    localparam int          LAT    = WIDTH + 1;

    logic                 clk;
    logic                 rst_n;
    logic                 req0, req1;
    logic [WIDTH-1:0]     num0, num1;
    logic                 ack0, ack1, busy, done, done_id;
    logic [4*DIGITS-1:0]  bcdnum;

    int checks = 0;
    int errors = 0;

    bcd_conv_arbiter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk_pi     (clk),
        .rst_n_pi   (rst_n),
        .req0_pi    (req0),
        .num0_pi    (num0),
        .req1_pi    (req1),
        .num1_pi    (num1),
        .ack0_po    (ack0),
        .ack1_po    (ack1),
        .busy_po    (busy),
        .done_po    (done),
        .done_id_po (done_id),
        .bcdnum_po  (bcdnum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decimal digits of v by plain division.
    function automatic logic [11:0] bcd_of(input int v);
        logic [11:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input bit id, output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if ((id ? ack1 : ack0) === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_done(output int n);
        n = 99;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit          id;
        logic [7:0]  num;
        logic [11:0] exp_bcd;
    } vec_t;

    // Randomized sweep state.
    bit drv_done0, drv_done1;

    task automatic drive(input bit id);
        int lo;
        int w;
        lo = id ? 128 : 0;
        for (int v = lo; v < lo + 128; v++) begin
            repeat ($urandom_range(3)) @(negedge clk);
            @(negedge clk);
            if (id) begin req1 = 1'b1; num1 = 8'(v); end
            else    begin req0 = 1'b1; num0 = 8'(v); end
            w = 0;
            do begin
                @(negedge clk);
                w++;
            end while (!(id ? ack1 : ack0) && w < 60);
            if (w >= 60) begin
                errors++;
                $display("FAIL rand_ack_timeout: requester %0d value %0d got no ack", id, v);
            end
            if (id) req1 = 1'b0;
            else    req0 = 1'b0;
        end
        if (id) drv_done1 = 1'b1;
        else    drv_done0 = 1'b1;
    endtask

    typedef struct {
        bit          id;
        logic [11:0] bcd;
        int          due;
    } exp_t;

    task automatic monitor();
        exp_t q[$];
        exp_t e;
        int   cyc;
        int   cool;
        bit   lastg;
        bit   g, ea0, ea1, ed;
        cyc   = 0;
        cool  = 0;
        lastg = 1'b1;
        while (cyc < 20000) begin
            tick();
            cyc++;
            ea0 = 1'b0;
            ea1 = 1'b0;
            // Engine free and someone asking: grant, alternating on ties.
            if (cool == 0 && (req0 || req1)) begin
                g     = (req0 && req1) ? !lastg : req1;
                lastg = g;
                cool  = LAT;
                e.id  = g;
                e.bcd = bcd_of(int'(g ? num1 : num0));
                e.due = cyc + LAT;
                q.push_back(e);
                ea0   = !g;
                ea1   = g;
            end else if (cool > 0) begin
                cool--;
            end
            chk("rand_ack0", 32'(ack0), 32'(ea0));
            chk("rand_ack1", 32'(ack1), 32'(ea1));
            chk("rand_busy", 32'(busy), 32'(cool > 0));
            ed = (q.size() > 0) && (q[0].due == cyc);
            chk("rand_done", 32'(done), 32'(ed));
            if (ed) begin
                e = q.pop_front();
                chk("rand_bcd", 32'(bcdnum), 32'(e.bcd));
                chk("rand_id", 32'(done_id), 32'(e.id));
            end
            if (drv_done0 && drv_done1 && q.size() == 0 && cool == 0) break;
        end
        if (cyc >= 20000) begin
            errors++;
            $display("FAIL rand_timeout: sweep did not complete, %0d pending", q.size());
        end
    endtask

    initial begin
        vec_t vecs[8];
        int   n, cnt, seen;

        vecs[0] = '{0, 8'd255, 12'h255};
        vecs[1] = '{0, 8'd0,   12'h000};
        vecs[2] = '{0, 8'd100, 12'h100};
        vecs[3] = '{1, 8'd9,   12'h009};
        vecs[4] = '{1, 8'd10,  12'h010};
        vecs[5] = '{0, 8'd99,  12'h099};
        vecs[6] = '{1, 8'd128, 12'h128};
        vecs[7] = '{1, 8'd199, 12'h199};

        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0; num0 = '0; num1 = '0;
        drv_done0 = 1'b0; drv_done1 = 1'b0;
        #1;
        chk("reset_ack0", 32'(ack0), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_bcd", 32'(bcdnum), 0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single-requester conversions.
        foreach (vecs[k]) begin
            if (vecs[k].id) begin req1 = 1'b1; num1 = vecs[k].num; end
            else            begin req0 = 1'b1; num0 = vecs[k].num; end
            wait_ack(vecs[k].id, n);
            chk("tbl_ack_lat", 32'(n), 1);
            chk("tbl_ack_excl", 32'(ack0 & ack1), 0);
            req0 = 1'b0;
            req1 = 1'b0;
            chk("tbl_busy", 32'(busy), 1);
            wait_done(n);
            chk("tbl_done_lat", 32'(n), LAT);
            chk("tbl_bcd", 32'(bcdnum), 32'(vecs[k].exp_bcd));
            chk("tbl_id", 32'(done_id), 32'(vecs[k].id));
            tick();
            chk("tbl_done_pulse", 32'(done), 0);
            chk("tbl_idle", 32'(busy), 0);
        end
        repeat (3) tick();
        chk("bcd_hold", 32'(bcdnum), 32'h199);

        // Tie after reset: req0 first, then req1, then req0 again.
        do_reset();
        req0 = 1'b1; num0 = 8'd42;
        req1 = 1'b1; num1 = 8'd199;
        wait_ack(0, n);
        chk("tie_ack0_lat", 32'(n), 1);
        chk("tie_ack1_low", 32'(ack1), 0);
        req0 = 1'b0;
        wait_done(n);
        chk("tie_done0_lat", 32'(n), LAT);
        chk("tie_bcd0", 32'(bcdnum), 32'h042);
        chk("tie_id0", 32'(done_id), 0);
        tick();
        chk("tie_ack1", 32'(ack1), 1);
        req1 = 1'b0;
        wait_done(n);
        chk("tie_bcd1", 32'(bcdnum), 32'h199);
        chk("tie_id1", 32'(done_id), 1);
        req0 = 1'b1; num0 = 8'd7;
        req1 = 1'b1; num1 = 8'd8;
        tick();
        chk("tie2_ack0", 32'(ack0), 1);
        chk("tie2_ack1", 32'(ack1), 0);
        req0 = 1'b0;
        wait_done(n);
        chk("tie2_bcd0", 32'(bcdnum), 32'h007);
        tick();
        chk("tie2_ack1_next", 32'(ack1), 1);
        req1 = 1'b0;
        wait_done(n);
        chk("tie2_bcd1", 32'(bcdnum), 32'h008);

        // Request arriving during SHIFT waits for IDLE.
        req0 = 1'b1; num0 = 8'd77;
        wait_ack(0, n);
        req0 = 1'b0;
        repeat (3) tick();
        req1 = 1'b1; num1 = 8'd200;
        cnt = 3;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            cnt++;
            if (done) chk("shift_req_bcd0", 32'(bcdnum), 32'h077);
            if (ack1) begin
                seen = 1;
                break;
            end
        end
        chk("shift_req_gap", 32'(seen ? cnt : 99), WIDTH + 2);
        req1 = 1'b0;
        wait_done(n);
        chk("shift_req_bcd1", 32'(bcdnum), 32'h200);
        chk("shift_req_id1", 32'(done_id), 1);

        // Reset at SHIFT cycle 4 aborts the conversion.
        req0 = 1'b1; num0 = 8'd123;
        wait_ack(0, n);
        req0 = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_bcd", 32'(bcdnum), 0);
        chk("abort_id", 32'(done_id), 0);
        chk("abort_done", 32'(done), 0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done) cnt++;
        end
        chk("abort_no_done", 32'(cnt), 0);
        req0 = 1'b1; num0 = 8'd123;
        wait_ack(0, n);
        chk("abort_reack", 32'(n), 1);
        req0 = 1'b0;
        wait_done(n);
        chk("abort_redo_bcd", 32'(bcdnum), 32'h123);

        // Every operand through both requesters with random gaps.
        do_reset();
        fork
            drive(0);
            drive(1);
            monitor();
        join

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
